// File: rtl/mcpu_gpu_pkg.sv
// Shared framebuffer geometry and fetch FSM encoding for the MCPU GPU blocks.
package mcpu_gpu;

  localparam int unsigned FB_WIDTH         = 256;
  localparam int unsigned FB_HEIGHT        = 240;
  localparam int unsigned FB_WORDS_PER_ROW = 16;
  localparam int unsigned FB_BPP           = 2;
  localparam int unsigned FB_LAST_WORD     = FB_WORDS_PER_ROW - 1;

  // Palette reset contents, entry 3 in the top nibble down to entry 0.
  localparam logic [15:0] PAL_RESET = 16'hFA50;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_CAPT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mcpu_fb_fetch.sv
// Single-word RAM read sequencer: holds rd_req with a stable address until
// granted, then flags the cycle in which read data must be captured.
module mcpu_fb_fetch
  import mcpu_gpu::*;
#(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] FB_BASE    = DATA_WIDTH'(16'h0800)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic                  rd_ack_i,
  output logic                  rd_req_o,
  output logic [DATA_WIDTH-1:0] rd_addr_o,
  output logic                  idle_c,
  output logic                  capt_c
);

  fetch_state_e          state_q;
  logic                  rd_req_q;
  logic [DATA_WIDTH-1:0] rd_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH_IDLE;
      rd_req_q  <= 1'b0;
      rd_addr_q <= FB_BASE;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (start_i) begin
            state_q   <= FETCH_REQ;
            rd_req_q  <= 1'b1;
            rd_addr_q <= addr_i;
          end
        end
        FETCH_REQ: begin
          if (rd_ack_i) begin
            state_q  <= FETCH_CAPT;
            rd_req_q <= 1'b0;
          end
        end
        FETCH_CAPT: state_q <= FETCH_IDLE;
        default:    state_q <= FETCH_IDLE;
      endcase
    end
  end

  assign rd_req_o  = rd_req_q;
  assign rd_addr_o = rd_addr_q;
  assign idle_c    = (state_q == FETCH_IDLE);
  assign capt_c    = (state_q == FETCH_CAPT);

endmodule

// File: rtl/mcpu_fb_scanout.sv
// 2bpp framebuffer scanout: double-buffered word fetch (cur/nxt), 2x pixel
// scaling from hvsync counters, 4-entry palette and sticky underrun flag.
module mcpu_fb_scanout
  import mcpu_gpu::*;
#(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] FB_BASE    = DATA_WIDTH'(16'h0800),
  parameter int unsigned           H_MAX      = 308,
  parameter int unsigned           V_MAX      = 261
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            hpos,
  input  logic [8:0]            vpos,
  input  logic                  display_on,
  output logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  pal_we,
  input  logic [1:0]            pal_idx,
  input  logic [3:0]            pal_data,
  output logic [3:0]            rgb,
  output logic                  underrun
);

  logic [8:0]            next_v_c;
  logic                  pre_trig_c, word_trig_c, trig_c;
  logic                  line_load_c, word_load_c, load_c, start_c;
  logic                  idle_c, capt_c;
  logic [7:0]            fetch_row_c;
  logic [3:0]            fetch_word_c;
  logic [DATA_WIDTH-1:0] fetch_addr_c;
  logic [2:0]            pix_p_c;
  logic [4:0]            pix_sh_c;
  logic [1:0]            pix_c;

  logic [DATA_WIDTH-1:0] cur_q, nxt_q;
  logic                  nxt_valid_q, underrun_q;
  logic [3:0]            rgb_q;
  logic [3:0][3:0]       pal_q;

  // Fetch/load scheduling decoded from the beam position; vblank lines never
  // load, so an empty nxt there is not an underrun.
  always_comb begin
    next_v_c     = (vpos == 9'(V_MAX)) ? 9'd0 : vpos + 9'd1;
    pre_trig_c   = (hpos == 9'(FB_WIDTH)) && (next_v_c < 9'(FB_HEIGHT));
    word_trig_c  = !hpos[8] && (hpos[3:0] == 4'd0) &&
                   (hpos[7:4] != 4'(FB_LAST_WORD)) && (vpos < 9'(FB_HEIGHT));
    trig_c       = pre_trig_c || word_trig_c;
    fetch_row_c  = pre_trig_c ? next_v_c[8:1] : vpos[8:1];
    fetch_word_c = pre_trig_c ? 4'd0 : hpos[7:4] + 4'd1;
    fetch_addr_c = FB_BASE + DATA_WIDTH'(32'(fetch_row_c) * FB_WORDS_PER_ROW +
                                         32'(fetch_word_c));
    line_load_c  = (hpos == 9'(H_MAX)) && (next_v_c < 9'(FB_HEIGHT));
    word_load_c  = (hpos < 9'(FB_WIDTH - 1)) && (hpos[3:0] == 4'hF) &&
                   (vpos < 9'(FB_HEIGHT));
    load_c       = line_load_c || word_load_c;
    start_c      = trig_c && idle_c;
    pix_p_c      = hpos[3:1];
    pix_sh_c     = 5'(DATA_WIDTH - FB_BPP) - 5'(32'(pix_p_c) * FB_BPP);
    pix_c        = 2'(cur_q >> pix_sh_c);
  end

  mcpu_fb_fetch #(
    .DATA_WIDTH (DATA_WIDTH),
    .FB_BASE    (FB_BASE)
  ) u_fetch (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_c),
    .addr_i    (fetch_addr_c),
    .rd_ack_i  (rd_ack),
    .rd_req_o  (rd_req),
    .rd_addr_o (rd_addr),
    .idle_c    (idle_c),
    .capt_c    (capt_c)
  );

  // Later assignments win: a capture landing with a load/start keeps nxt valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q       <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      rgb_q       <= 4'h0;
      pal_q       <= PAL_RESET;
    end else begin
      rgb_q <= display_on ? pal_q[pix_c] : 4'h0;
      if (pal_we) pal_q[pal_idx] <= pal_data;
      if (load_c) begin
        cur_q       <= nxt_valid_q ? nxt_q : '0;
        nxt_valid_q <= 1'b0;
      end
      if (start_c) nxt_valid_q <= 1'b0;
      if (capt_c) begin
        nxt_q       <= rd_data;
        nxt_valid_q <= 1'b1;
      end
      if ((load_c && !nxt_valid_q) || (trig_c && !idle_c)) underrun_q <= 1'b1;
    end
  end

  assign rgb      = rgb_q;
  assign underrun = underrun_q;

endmodule

// File: doc/mcpu_fb_scanout.md
MCPU_FB_SCANOUT -- requirements
Module: mcpu_fb_scanout

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, RAM word width.
REQ-002 SHALL have parameter FB_BASE, default 16'h0800, word address of framebuffer row 0 word 0.
REQ-003 SHALL have parameter H_MAX, default 308, last hpos value of a line.
REQ-004 SHALL have parameter V_MAX, default 261, last vpos value of a frame.
REQ-005 clk  input  1  sole clock; all state changes on posedge clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 hpos  input  9  horizontal counter from hvsync_generator.
REQ-008 vpos  input  9  vertical counter from hvsync_generator.
REQ-009 display_on  input  1  visible-area flag from hvsync_generator.
REQ-010 rd_req  output  1  read request to RAM arbiter.
REQ-011 rd_addr  output  DATA_WIDTH  word address, stable while rd_req high.
REQ-012 rd_ack  input  1  grant; request accepted on an edge where rd_req and rd_ack are both high.
REQ-013 rd_data  input  DATA_WIDTH  read data, valid in the cycle after acceptance.
REQ-014 pal_we  input  1  palette write strobe.
REQ-015 pal_idx  input  2  palette entry written.
REQ-016 pal_data  input  4  palette colour written.
REQ-017 rgb  output  4  registered pixel colour.
REQ-018 underrun  output  1  sticky flag: word not fetched in time.

Function
REQ-019 Framebuffer SHALL be 128x120 source pixels at 2 bpp, 8 pixels per word, 16 words per row, scaled 2x to 256x240; addresses span FB_BASE..FB_BASE+0x77F.
REQ-020 Visible pixel (hpos,vpos) SHALL map to word FB_BASE + (vpos>>1)*16 + hpos[7:4], pixel p = hpos[3:1], bits [15-2p:14-2p] (MSB-first).
REQ-021 Each cycle, rgb SHALL register palette[pixel of cur word at hpos[3:1]] when display_on, else 4'h0 (one-cycle latency from hpos).
REQ-022 Line prefetch: at hpos==256 on line v, if next line n=(v==V_MAX?0:v+1) is <240, SHALL fetch word 0 of row n>>1 into nxt.
REQ-023 cur SHALL load from nxt at hpos==H_MAX (line start) and at hpos[3:0]==15 with hpos<255 (word boundary); nxt marked empty on load.
REQ-024 At hpos[3:0]==0 with hpos[7:4]<15 and vpos<240, SHALL fetch word hpos[7:4]+1 of row vpos>>1 into nxt.
REQ-025 Fetch FSM states IDLE -> REQ (rd_req=1 until rd_ack) -> CAPT (nxt<=rd_data, nxt_valid=1) -> IDLE; rd_req SHALL never drop before acceptance.
REQ-026 If a load occurs with nxt_valid=0, cur SHALL become 0 (palette entry 0 shown) and underrun SHALL set; the pending fetch still completes into nxt but is discarded at the next fetch trigger.
REQ-027 A fetch trigger while FSM is not IDLE SHALL be dropped and SHALL set underrun.
REQ-028 pal_we SHALL update palette[pal_idx] at the edge; a pixel read of the same entry that cycle uses the old value.
REQ-029 underrun SHALL clear only on reset.

Reset
REQ-030 Reset SHALL force rgb=0, rd_req=0, rd_addr=FB_BASE, underrun=0, cur=0, nxt=0, nxt_valid=0, FSM=IDLE, palette={0:4'h0,1:4'h5,2:4'hA,3:4'hF}.
REQ-031 Reset asserted mid-fetch SHALL abandon the request immediately; first valid frame follows the next line prefetch after deassertion.

Structure
REQ-032 FB geometry constants (256, 240, 16 words/row, 2 bpp) and FSM state encoding SHALL live in a shared mcpu_gpu package.
REQ-033 Fetch FSM SHALL be one sub-module, mcpu_fb_fetch; pixel shift/palette stays in top.

Verification
REQ-034 RAM filled with word 0xE4E4, rd_ack tied 1 -> line 0 rgb repeats 3,3? no: pixel pairs F,A,5,0 each held 2 pixels, underrun=0.
REQ-035 Write ram[0x0800]=0xFFFF, rest 0 -> rgb=4'hF for hpos 0..15 on vpos 0 and 1 only; address 0x0800 requested twice per frame.
REQ-036 rd_ack held 0 for whole line 10 -> rgb=0 for that line, underrun=1 and stays 1.
REQ-037 pal_we with pal_idx=3, pal_data=4'h7 during frame -> subsequent 0xFFFF pixels show 4'h7.
REQ-038 Reset pulsed at hpos=100 mid-fetch -> rd_req=0 same cycle, rgb=0, correct output from next frame line 0.
REQ-039 Last visible fetch address checked = 16'h0F7F at vpos 239; no rd_req for vpos 240..V_MAX except prefetch at vpos V_MAX.
